// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives instr_fetch PC controls, datapath controls and the retired-instruction count.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic        branch,
  output logic        zero_out,
  output logic [1:0]  jump,
  output logic        jal,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic        ext_zero,
  output logic [2:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SLT   = 6'h2A;

  state_t cur, nxt;

  logic is_r, is_add, is_sub, is_slt, is_jr, is_j, is_jal;
  logic is_bne, is_xori, is_lw, is_sw, goes_exec;

  // Instruction class decode from the IR fields
  always_comb begin
    is_r      = (opcode == OP_R);
    is_add    = is_r && (funct == F_ADD);
    is_sub    = is_r && (funct == F_SUB);
    is_slt    = is_r && (funct == F_SLT);
    is_jr     = is_r && (funct == F_JR);
    is_j      = (opcode == OP_J);
    is_jal    = (opcode == OP_JAL);
    is_bne    = (opcode == OP_BNE);
    is_xori   = (opcode == OP_XORI);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    goes_exec = is_lw | is_sw | is_bne | is_xori | is_add | is_sub | is_slt;
  end

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  // Retired-instruction counter, one tick per PC update, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     instr_count <= '0;
    else if (pc_we) instr_count <= instr_count + 32'd1;
  end

  // Next-state and Moore outputs (no dependence on mem_ack except for the MEM exit)
  always_comb begin
    nxt      = cur;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    branch   = 1'b0;
    zero_out = 1'b0;
    jump     = 2'b00;
    jal      = 1'b0;
    reg_we   = 1'b0;
    reg_dst  = 2'b00;
    wb_sel   = 2'b00;
    alu_src  = 1'b0;
    ext_zero = 1'b0;
    alu_op   = 3'b000;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    trap     = 1'b0;

    // ALU controls are set in EXEC and held through MEM and WB
    if (cur == EXEC || cur == MEM || cur == WB) begin
      alu_src  = is_lw | is_sw | is_xori;
      ext_zero = is_xori;
      if (is_bne)       alu_op = 3'b001;
      else if (is_xori) alu_op = 3'b010;
      else if (is_sub)  alu_op = 3'b001;
      else if (is_slt)  alu_op = 3'b011;
      else              alu_op = 3'b000;
    end

    case (cur)
      FETCH: begin
        ir_we = 1'b1;
        nxt   = DECODE;
      end
      DECODE: begin
        if (is_j) begin
          pc_we = 1'b1;
          jump  = 2'b10;
          nxt   = FETCH;
        end else if (is_jal) begin
          pc_we   = 1'b1;
          jump    = 2'b10;
          jal     = 1'b1;
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          wb_sel  = 2'b10;
          nxt     = FETCH;
        end else if (is_jr) begin
          pc_we = 1'b1;
          jump  = 2'b01;
          nxt   = FETCH;
        end else if (goes_exec) begin
          nxt = EXEC;
        end else begin
          nxt = TRAP;
        end
      end
      EXEC: begin
        if (is_bne) begin
          branch   = 1'b1;
          zero_out = ~alu_zero;
          pc_we    = 1'b1;
          nxt      = FETCH;
        end else if (is_lw || is_sw) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ack) nxt = WB;
      end
      WB: begin
        pc_we = 1'b1;
        if (is_r) begin
          reg_we  = 1'b1;
          reg_dst = 2'b01;
        end else if (is_xori) begin
          reg_we = 1'b1;
        end else if (is_lw) begin
          reg_we = 1'b1;
          wb_sel = 2'b01;
        end
        nxt = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
        nxt  = TRAP;
      end
      default: nxt = FETCH;
    endcase
  end

  assign state = cur;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the MIPS CPU. It sequences fetch, decode, execute, memory and writeback for each instruction and drives `instr_fetch`: its `branch`, `zero`, `jump` and `jal` inputs, plus a new `pc_we` gate so the PC advances exactly once per instruction. It also drives the register-file, ALU and data-memory controls, handshakes with data memory, and counts retired instructions. It sits between the IR and the datapath in the CPU top level.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], stable from the cycle after FETCH.
- `funct` in 6: IR[5:0].
- `alu_zero` in 1: ALU result == 0.
- `mem_ack` in 1: data memory completion, sampled at clk.
- `ir_we` out 1: load IR from instruction memory.
- `pc_we` out 1: PC update enable for `instr_fetch`.
- `branch` out 1: to `instr_fetch.branch`.
- `zero_out` out 1: to `instr_fetch.zero` (branch-taken qualifier).
- `jump` out 2: to `instr_fetch.jump`. 00 = sequential/branch, 01 = JR (Da), 10 = J/JAL target.
- `jal` out 1: to `instr_fetch.jal`.
- `reg_we` out 1: register file write enable.
- `reg_dst` out 2: write register select. 00 = rt, 01 = rd, 10 = $31.
- `wb_sel` out 2: write data select. 00 = ALU, 01 = memory, 10 = PC+4 (`outAdder`).
- `alu_src` out 1: 0 = Db, 1 = extended imm16.
- `ext_zero` out 1: 1 = zero-extend imm16, 0 = sign-extend.
- `alu_op` out 3: 000 add, 001 sub, 010 xor, 011 slt.
- `mem_req` out 1: data memory request.
- `mem_we` out 1: data memory write (valid while `mem_req` is high).
- `trap` out 1: illegal instruction; CPU halted.
- `state` out 3: current state, for debug.
- `instr_count` out 32: retired-instruction counter.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Moore outputs. Every output is a function of `state`, `opcode`, `funct` and `alu_zero` only; no output depends on `mem_ack`.
- FETCH:
  - `ir_we`=1.
  - Next state is always DECODE.
- DECODE:
  - J (0x02): `pc_we`=1, `jump`=10. Next state FETCH.
  - JAL (0x03): `pc_we`=1, `jump`=10, `jal`=1, `reg_we`=1, `reg_dst`=10, `wb_sel`=10. Next state FETCH.
  - JR (opcode 0x00, funct 0x08): `pc_we`=1, `jump`=01. Next state FETCH.
  - LW 0x23, SW 0x2B, BNE 0x05, XORI 0x0E, R-type ADD 0x20 / SUB 0x22 / SLT 0x2A: next state EXEC.
  - Any other opcode/funct: next state TRAP.
- EXEC:
  - `alu_op`: add for LW/SW, sub for BNE, xor for XORI; for R-type, taken from `funct`.
  - `alu_src`=1 for LW/SW/XORI.
  - `ext_zero`=1 for XORI.
  - BNE: `branch`=1, `zero_out`=~`alu_zero`, `pc_we`=1. Next state FETCH.
  - LW/SW: next state MEM.
  - Others: next state WB.
- MEM:
  - `mem_req`=1; `mem_we`=1 for SW.
  - The ALU controls from EXEC are held.
  - Stays in MEM until `mem_ack` is sampled high, then goes to WB.
- WB:
  - `pc_we`=1 with `jump`=00 and `branch`=0.
  - R-type: `reg_we`=1, `reg_dst`=01, `wb_sel`=00.
  - XORI: `reg_we`=1, `reg_dst`=00, `wb_sel`=00.
  - LW: `reg_we`=1, `reg_dst`=00, `wb_sel`=01.
  - SW: `reg_we`=0.
  - ALU controls are held.
  - Next state FETCH.
- TRAP:
  - `trap`=1; all other outputs 0.
  - Held until reset.
- `instr_count` increments by 1 on every clock edge where `pc_we`=1 and wraps from 0xFFFFFFFF to 0.
- In any state, signals not listed for that state are 0.

## Timing
- Reset (`rst_n`=0, takes effect immediately, no clock needed):
  - `state`=FETCH and `instr_count`=0.
  - With state at FETCH, `ir_we`=1 and every other output is 0 while reset is held.
  - Reset asserted in the middle of an instruction, including MEM, aborts it: `mem_req` drops asynchronously, and no `pc_we` or `reg_we` is issued for the aborted instruction.
- First FETCH after reset release is the first rising edge with `rst_n`=1.
- Latency in cycles, FETCH = cycle 0:
  - J / JAL / JR: 2.
  - BNE: 3.
  - ADD / SUB / SLT / XORI: 4.
  - SW / LW: 5 + w, where w is the number of MEM cycles with `mem_ack`=0.
- `pc_we` is high for exactly one cycle per instruction, in that instruction's last cycle. `jump`, `branch`, `zero_out` and `jal` are valid in that same cycle.
- `mem_ack` is ignored outside MEM.
- An ack arriving in the first MEM cycle gives a single-cycle MEM.
- `mem_req` stays high continuously from MEM entry up to and including the ack cycle.

## Test plan
- Reset: pull `rst_n` low during MEM of an LW. Required: `state`=0, `mem_req`=0, `instr_count`=0 immediately, before any clock edge. After release, `ir_we`=1 at cycle 0.
- ADD (opcode 0x00, funct 0x20). Required:
  - cycle 0: `ir_we`=1.
  - cycle 2: `alu_op`=000.
  - cycle 3: `pc_we`=1, `reg_we`=1, `reg_dst`=01, `wb_sel`=00.
  - `instr_count`=1 after cycle 3.
- LW (0x23) with `mem_ack` first high at cycle 6. Required:
  - `mem_req`=1 for cycles 3–6, `mem_we`=0.
  - cycle 7: `pc_we`=1, `reg_we`=1, `wb_sel`=01.
- BNE (0x05). Required:
  - With `alu_zero`=0: cycle 2 has `pc_we`=1, `branch`=1, `zero_out`=1.
  - Repeat with `alu_zero`=1: cycle 2 has `zero_out`=0.
- JAL (0x03), then JR (0x00/0x08). Required:
  - JAL cycle 1: `pc_we`=1, `jump`=10, `jal`=1, `reg_we`=1, `reg_dst`=10, `wb_sel`=10.
  - JR cycle 1: `jump`=01, `reg_we`=0.
- Illegal opcode 0x3F. Required:
  - From cycle 2: `state`=7, `trap`=1.
  - `pc_we`=0 for 20 further cycles and `instr_count` unchanged.
  - Pulsing `rst_n` returns the FSM to FETCH.
